fifo_sync_param: RTL
====================

// Module: fifo_sync_param
// PURPOSE
//  Parametrised synchronous FIFO. Generalises the fixed 4-bit buffer in data width and depth.
//  Adds almost-full/almost-empty thresholds, a read-valid strobe, and write-through when full with a simultaneous read.
//  Single clock domain. Used between producer/consumer stages in the datapath.
// PARAMETERS
//  DATA_W     8   data word width in bits
//  ADDR_W     4   pointer width; DEPTH = 2**ADDR_W entries
//  AF_THRESH  14  almost_full asserts when fifo_counter >= AF_THRESH
//  AE_THRESH  2   almost_empty asserts when fifo_counter <= AE_THRESH
// PORTS
//  clk           in   1         system clock, rising edge
//  rst           in   1         asynchronous active-high reset
//  wr_en         in   1         push request
//  buf_in        in   DATA_W    push data
//  rd_en         in   1         pop request
//  buf_out       out  DATA_W    popped data, registered
//  rd_valid      out  1         buf_out updated this cycle (1-cycle pulse)
//  buf_empty     out  1         fifo_counter == 0
//  buf_full      out  1         fifo_counter == DEPTH
//  almost_empty  out  1         fifo_counter <= AE_THRESH
//  almost_full   out  1         fifo_counter >= AF_THRESH
//  fifo_counter  out  ADDR_W+1  current occupancy, 0..DEPTH
//  err_clr       in   1         clears sticky error flags (see CONFIGURATION)
//  overflow      out  1         sticky: push rejected
//  underflow     out  1         sticky: pop rejected
// BEHAVIOUR
//  - Reset (async, rst=1): pointers=0, fifo_counter=0, buf_out=0, rd_valid=0, overflow=underflow=0.
//    Memory is not reset. Reset mid-operation discards all contents immediately.
//  - Status flags decode combinationally from the fifo_counter register. They take no extra cycle.
//    After reset: buf_empty=1, buf_full=0, almost_empty=1, almost_full=(AF_THRESH==0).
//  - do_rd = rd_en & !buf_empty.
//  - do_wr = wr_en & (!buf_full | do_rd).
//  - Full + wr_en + rd_en: both the pop and the push happen. Count stays at DEPTH.
//  - Empty + wr_en + rd_en: only the push happens. Count becomes 1. No read-through.
//  - Push: mem[wr_ptr] <= buf_in; wr_ptr increments mod DEPTH (natural wrap of ADDR_W bits).
//  - Pop: buf_out <= mem[rd_ptr]; rd_ptr increments mod DEPTH. rd_valid=1 the next cycle.
//    Read latency is 1 clock from the rd_en edge to buf_out/rd_valid.
//  - Rejected pop (rd_en & buf_empty): buf_out holds its value; rd_valid=0.
//  - Counter: +1 on do_wr only; -1 on do_rd only; unchanged on both or neither.
//    It never exceeds DEPTH and never goes below 0.
//  - Rejected push (wr_en & buf_full & !do_rd): data dropped; memory and pointers unchanged.
//  - Elaboration check: require AE_THRESH < AF_THRESH <= DEPTH. Otherwise $error.
// CONFIGURATION
//  FIFO_ERR_FLAGS_EN defined:
//    - overflow sets on a rejected push; underflow sets on a rejected pop. Both update at the clock edge.
//    - Both stay set until err_clr=1 at a clock edge or rst.
//    - If err_clr and a new error occur in the same cycle, the new error wins (flag stays 1).
//  FIFO_ERR_FLAGS_EN undefined:
//    - overflow and underflow are tied to 0; err_clr is ignored.
//    - The port list is unchanged.
// TESTING  (DATA_W=8, ADDR_W=2 -> DEPTH=4, AF_THRESH=3, AE_THRESH=1)
//  1. Reset, push 0xA1,0xB2,0xC3,0xD4, then pop x4.
//     -> buf_out 0xA1,0xB2,0xC3,0xD4 one cycle after each rd_en, with rd_valid=1.
//     -> Count goes 1,2,3,4: almost_full at 3, buf_full at 4; buf_empty after the last pop.
//  2. Full FIFO, wr_en=rd_en=1 with buf_in=0xE5.
//     -> buf_out=0xA1, count stays 4, 0xE5 is stored.
//     -> Then pop x4 returns 0xB2,0xC3,0xD4,0xE5.
//  3. Empty FIFO, wr_en=rd_en=1 with buf_in=0x55.
//     -> rd_valid=0, buf_out unchanged, count=1.
//     -> The next pop returns 0x55.
//  4. Pointer wrap: 10 rounds of push 3 / pop 3 with incrementing data.
//     -> Data order is preserved across wrap; count returns to 0 each round.
//  5. With FIFO_ERR_FLAGS_EN: push while full -> overflow=1 and count stays 4.
//     -> Pop while empty -> underflow=1.
//     -> err_clr for 1 cycle -> both flags 0.
//     -> Without the macro, both flags stay 0.
//  6. Assert rst mid-burst with count=3.
//     -> buf_empty=1, count=0, buf_out=0, rd_valid=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with almost-full/empty flags; 1-cycle registered read (buf_out/rd_valid).
// Backpressure: pushes when full are dropped unless a pop happens in the same cycle; pops when empty are ignored.
// Optional sticky overflow/underflow flags under macro FIFO_ERR_FLAGS_EN (tied to 0 when undefined).
module fifo_sync_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] buf_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] buf_out,
    output logic              rd_valid,
    output logic              buf_empty,
    output logic              buf_full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   fifo_counter,
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_thresh_bad
        $error("fifo_sync_param: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] buf_out_q, buf_out_d;
    logic              rd_valid_q;
    logic              do_wr, do_rd;

    // Flags decode straight from the count register so they track it with no extra delay.
    assign buf_empty    = (cnt_q == '0);
    assign buf_full     = (cnt_q == DEPTH_C);
    assign almost_empty = (cnt_q <= AE_C);
    assign almost_full  = (cnt_q >= AF_C);
    assign fifo_counter = cnt_q;
    assign buf_out      = buf_out_q;
    assign rd_valid     = rd_valid_q;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign do_rd = rd_en & ~buf_empty;
    assign do_wr = wr_en & (~buf_full | do_rd);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        buf_out_d = buf_out_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
            buf_out_d = mem_q[rd_ptr_q];
        end
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            buf_out_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            buf_out_q  <= buf_out_d;
            rd_valid_q <= do_rd;
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= buf_in;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_comb begin
        overflow_d  = (err_clr ? 1'b0 : overflow_q)  | (wr_en & ~do_wr);
        underflow_d = (err_clr ? 1'b0 : underflow_q) | (rd_en & buf_empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule
